// File: rtl/audio_pkg.sv
// Shared audio types and frame geometry for the note-playback pipeline tail.
// The serializer and its FIFO both use these definitions.
package audio_pkg;
    localparam int SAMPLE_WIDTH = 16;
    localparam int FRAME_BITS   = 32;
    localparam int CHAN_BITS    = 16;
    localparam int BITCNT_W     = $clog2(FRAME_BITS);

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO. Occupancy comes from a counter, not from pointer compare.
// A pop on an empty FIFO is ignored. A push while full is accepted only if a pop happens in the same cycle.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [AW-1:0]           wptr_q, wptr_d;
    logic [AW-1:0]           rptr_q, rptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rptr_q];

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/codec_serializer.sv
// Left-justified mono serializer for the codec. It generates bclk and lrclk and sends
// each FIFO sample on both channels of a 32-bit frame, MSB first.
module codec_serializer
    import audio_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BCLK_DIV   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [SAMPLE_WIDTH-1:0]       sample_in,
    input  logic                          sample_ready_in,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          underrun
);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_MAX   = DIV_W'(BCLK_DIV - 1);
    localparam logic [BITCNT_W-1:0] BIT_LAST  = BITCNT_W'(FRAME_BITS - 1);
    localparam logic [BITCNT_W-1:0] BIT_RIGHT = BITCNT_W'(CHAN_BITS);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("codec_serializer: FIFO_DEPTH must be a power of two >= 2");
    end
    if (BCLK_DIV < 1) begin : g_bad_div
        $error("codec_serializer: BCLK_DIV must be >= 1");
    end

    logic [DIV_W-1:0]    div_q, div_d;
    logic                bclk_q, bclk_d;
    logic                lrclk_q, lrclk_d;
    logic                sdata_q, sdata_d;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    sample_t             shreg_q, shreg_d;
    sample_t             frame_q, frame_d;
    logic                overflow_q, overflow_d;
    logic                underrun_q, underrun_d;

    logic                div_wrap, shift_evt, fifo_pop;
    logic                fifo_full, fifo_empty;
    logic [SAMPLE_WIDTH-1:0] fifo_dout;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (SAMPLE_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (sample_ready_in),
        .pop   (fifo_pop),
        .din   (sample_in),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        div_d      = div_q;
        bclk_d     = bclk_q;
        lrclk_d    = lrclk_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        frame_d    = frame_q;
        underrun_d = 1'b0;
        fifo_pop   = 1'b0;

        div_wrap  = (div_q == DIV_MAX);
        shift_evt = div_wrap && bclk_q;

        if (div_wrap) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        // Everything the codec samples changes on the bclk falling edge.
        if (shift_evt) begin
            bitcnt_d = bitcnt_q + BITCNT_W'(1);
            if (bitcnt_q == BIT_LAST) begin
                lrclk_d = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = sample_t'(fifo_dout);
                    frame_d  = sample_t'(fifo_dout);
                end else begin
                    shreg_d    = '0;
                    frame_d    = '0;
                    underrun_d = 1'b1;
                end
            end else if (bitcnt_d == BIT_RIGHT) begin
                lrclk_d = 1'b1;
                shreg_d = frame_q;
            end else begin
                shreg_d = sample_t'({shreg_q[SAMPLE_WIDTH-2:0], 1'b0});
            end
        end

        sdata_d    = shreg_d[SAMPLE_WIDTH-1];
        // A same-cycle frame-start pop frees a slot, so that push is not dropped.
        overflow_d = sample_ready_in && fifo_full && !fifo_pop;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q      <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            bitcnt_q   <= BIT_LAST;
            shreg_q    <= '0;
            frame_q    <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            frame_q    <= frame_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    assign bclk     = bclk_q;
    assign lrclk    = lrclk_q;
    assign sdata    = sdata_q;
    assign overflow = overflow_q;
    assign underrun = underrun_q;
endmodule

// File: tb/tb_codec_serializer.sv
// Directed bench for codec_serializer with BCLK_DIV=1 and FIFO_DEPTH=4.
// With these settings frames start at clk edges 2+64k after reset release, and bit b of a frame lands on edge start+2b.
module tb_codec_serializer;
    logic        clk;
    logic        reset;
    logic [15:0] sample_in;
    logic        sample_ready_in;
    logic        bclk, lrclk, sdata;
    logic [2:0]  fifo_count;
    logic        overflow, underrun;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    codec_serializer #(
        .FIFO_DEPTH (4),
        .BCLK_DIV   (1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .sample_in       (sample_in),
        .sample_ready_in (sample_ready_in),
        .bclk            (bclk),
        .lrclk           (lrclk),
        .sdata           (sdata),
        .fifo_count      (fifo_count),
        .overflow        (overflow),
        .underrun        (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int e);
        while (cyc < e) step();
    endtask

    task automatic frame_chk(input string tag, input int start, input logic [15:0] exp);
        logic [31:0] w;
        logic [31:0] lr;
        w  = '0;
        lr = '0;
        for (int b = 0; b < 32; b++) begin
            goto(start + 2 * b);
            w  = {w[30:0], sdata};
            lr = {lr[30:0], lrclk};
        end
        chk({tag, "_left"},  {16'h0, w[31:16]}, {16'h0, exp});
        chk({tag, "_right"}, {16'h0, w[15:0]},  {16'h0, exp});
        chk({tag, "_lrclk"}, lr, 32'h0000_FFFF);
    endtask

    initial begin
        reset           = 1'b0;
        sample_in       = '0;
        sample_ready_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bclk",  32'(bclk), 0);
        chk("rst_lrclk", 32'(lrclk), 0);
        chk("rst_sdata", 32'(sdata), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ovf",   32'(overflow), 0);
        chk("rst_udr",   32'(underrun), 0);

        reset = 1'b1;
        cyc   = 0;

        // Idle frames: free-running clocks, silent data, one underrun per frame.
        for (int e = 1; e <= 130; e++) begin
            goto(e);
            chk("idle_bclk",  32'(bclk), 32'(e % 2));
            chk("idle_lrclk", 32'(lrclk), 32'((e >= 2) && (((e - 2) % 64) >= 32)));
            chk("idle_sdata", 32'(sdata), 0);
            chk("idle_udr",   32'(underrun), 32'((e >= 2) && (((e - 2) % 64) == 0)));
        end

        // Single sample.
        goto(131);
        sample_in = 16'hA5C3; sample_ready_in = 1'b1;
        goto(132);
        sample_ready_in = 1'b0;
        chk("single_count_push", 32'(fifo_count), 1);
        goto(193);
        chk("single_count_pre", 32'(fifo_count), 1);
        goto(194);
        chk("single_count_pop", 32'(fifo_count), 0);
        chk("single_udr", 32'(underrun), 0);
        frame_chk("single", 194, 16'hA5C3);
        goto(258);
        chk("empty_udr", 32'(underrun), 1);

        // Burst of five strobes into a 4-deep FIFO.
        goto(259);
        sample_ready_in = 1'b1;
        sample_in = 16'h1111; goto(260);
        sample_in = 16'h2222; goto(261);
        sample_in = 16'h3333; goto(262);
        sample_in = 16'h4444; goto(263);
        chk("burst_count4", 32'(fifo_count), 4);
        chk("burst_no_ovf", 32'(overflow), 0);
        sample_in = 16'h5555; goto(264);
        sample_ready_in = 1'b0;
        chk("burst_ovf", 32'(overflow), 1);
        chk("burst_count_full", 32'(fifo_count), 4);
        goto(265);
        chk("burst_ovf_clear", 32'(overflow), 0);

        // Strobe on the frame-start edge while full.
        goto(321);
        sample_in = 16'h6666; sample_ready_in = 1'b1;
        goto(322);
        sample_ready_in = 1'b0;
        chk("pp_count", 32'(fifo_count), 4);
        chk("pp_ovf", 32'(overflow), 0);
        chk("pp_udr", 32'(underrun), 0);
        frame_chk("fr1", 322, 16'h1111);
        frame_chk("fr2", 386, 16'h2222);
        frame_chk("fr3", 450, 16'h3333);
        frame_chk("fr4", 514, 16'h4444);
        frame_chk("fr_pp", 578, 16'h6666);
        goto(642);
        chk("drain_udr", 32'(underrun), 1);
        chk("drain_count", 32'(fifo_count), 0);

        // Negative full-scale sample.
        goto(650);
        sample_in = 16'h8000; sample_ready_in = 1'b1;
        goto(651);
        sample_ready_in = 1'b0;
        frame_chk("neg", 706, 16'h8000);

        // Reset in the middle of the left channel.
        goto(771);
        sample_in = 16'h8000; sample_ready_in = 1'b1;
        goto(772);
        sample_in = 16'h7FFF;
        goto(773);
        sample_ready_in = 1'b0;
        chk("mid_count2", 32'(fifo_count), 2);
        goto(834);
        chk("mid_msb", 32'(sdata), 1);
        chk("mid_count1", 32'(fifo_count), 1);
        goto(849);
        chk("mid_bclk_hi", 32'(bclk), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_bclk",  32'(bclk), 0);
        chk("mid_rst_lrclk", 32'(lrclk), 0);
        chk("mid_rst_sdata", 32'(sdata), 0);
        chk("mid_rst_count", 32'(fifo_count), 0);
        chk("mid_rst_ovf",   32'(overflow), 0);
        chk("mid_rst_udr",   32'(underrun), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc   = 0;
        goto(1);
        chk("rel_bclk_rise", 32'(bclk), 1);
        chk("rel_udr_pre", 32'(underrun), 0);
        goto(2);
        chk("rel_bclk_fall", 32'(bclk), 0);
        chk("rel_udr", 32'(underrun), 1);
        chk("rel_sdata", 32'(sdata), 0);
        chk("rel_count", 32'(fifo_count), 0);
        goto(3);
        chk("rel_udr_pulse", 32'(underrun), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/codec_serializer.md
# codec_serializer

Consumes the envelope-shaped 16-bit sample stream (`sample_out` / `sample_ready` pulse) produced by the dynamics stage and ships it to the audio codec as a left-justified serial stream. A small FIFO decouples the one-cycle `sample_ready` pulses from the fixed frame cadence. The block generates `bclk` and `lrclk` from the system clock and sends each sample as a mono pair on both channels. It sits at the tail of the note-playback pipeline, directly before the codec pins.

## Interface
- `FIFO_DEPTH`, default 4: sample FIFO entries; must be a power of two, ≥2.
- `BCLK_DIV`, default 4: `clk` cycles per `bclk` half-period; must be ≥1.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `sample_in`  in  16  signed sample from the dynamics stage.
- `sample_ready_in`  in  1  one-cycle strobe; `sample_in` is valid in this cycle.
- `bclk`  out  1  codec bit clock.
- `lrclk`  out  1  channel select: 0 = left, 1 = right.
- `sdata`  out  1  serial data, MSB first.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  one-cycle pulse when a strobe is dropped.
- `underrun`  out  1  one-cycle pulse when a frame starts with the FIFO empty.

## Operation
- Reset values: `bclk`=0, `lrclk`=0, `sdata`=0, `fifo_count`=0, `overflow`=0, `underrun`=0.
- Internal reset state: divider=0, bit counter=31, shift register=0.
- **Divider**: counts 0..BCLK_DIV-1. On wrap, `bclk` toggles. A falling edge is a wrap with `bclk`=1 before the toggle; it is the "shift event".
- **Bit counter**: 5 bits, increments modulo 32 on each shift event. One frame is 32 `bclk` periods.
- **Bit counter wraps to 0 (frame start)**:
  - `lrclk`←0.
  - If the FIFO is non-empty, pop the head into the shift register and latch it as the frame sample.
  - If the FIFO is empty, load 0 into both and pulse `underrun`.
- **Bit counter reaches 16**: `lrclk`←1; reload the shift register from the latched frame sample, so the right channel equals the left.
- **Other shift events**: shift the register left by one, filling with 0.
- `sdata` is always the shift register MSB, registered.
- **FIFO push**: on `sample_ready_in` when `fifo_count` < FIFO_DEPTH.
- **Push while full**:
  - With no pop in the same cycle: the sample is dropped and `overflow` pulses.
  - With a pop in the same cycle: the push is accepted and `fifo_count` is unchanged.
- **Simultaneous push and pop when empty**: the pop sees empty and underruns. The pushed sample is stored, and `fifo_count` becomes 1.
- Read and write pointers wrap modulo FIFO_DEPTH. Occupancy is tracked by `fifo_count`, not by pointer comparison.
- Samples are passed bit-exact, with no arithmetic. Two's-complement MSB goes first.

## Timing
- `bclk` period = 2·BCLK_DIV `clk` cycles. Frame = 64·BCLK_DIV `clk` cycles.
- First rising `bclk` edge: `clk` edge BCLK_DIV after reset release.
- First shift event and first frame start: edge 2·BCLK_DIV after reset release.
- `lrclk` and `sdata` change in the same `clk` cycle as the `bclk` falling edge, so the codec samples them on the rising `bclk` edge.
- A sample strobed at least one `clk` before a frame start is popped at that frame start.
- `overflow` and `underrun` assert in the cycle after the triggering event and last exactly one cycle.
- `fifo_count` reflects a push or pop one cycle after the event.
- Reset assertion mid-frame immediately forces all outputs and state to reset values and empties the FIFO. No partial frame completes.

## Structure
- Shared package `audio_pkg`:
  - `SAMPLE_WIDTH`=16.
  - `FRAME_BITS`=32.
  - `CHAN_BITS`=16.
  - a `sample_t` typedef (signed [15:0]).
- Sub-module `sample_fifo`: parameterized synchronous FIFO with push, pop, dout, count, full and empty.
- The divider, bit counter, shift register and flag logic live in `codec_serializer`.

## Test plan
- **Reset defaults**: BCLK_DIV=1 after reset release, no strobes.
  - `bclk` toggles every cycle.
  - `lrclk` goes high at bit 16 and low at bit 0.
  - `sdata`=0 throughout.
  - `underrun` pulses once per 64 cycles.
- **Single sample**: strobe 16'hA5C3.
  - Next frame: `sdata` shows 1010010111000011 during `lrclk`=0.
  - The same 16 bits repeat during `lrclk`=1.
  - `fifo_count` goes 1→0 at frame start.
- **Burst to overflow**: 5 back-to-back strobes with FIFO_DEPTH=4, no frame start during the burst.
  - `fifo_count` reaches 4.
  - `overflow` pulses on the 5th strobe only.
  - The next four frames carry samples 1–4 in order.
- **Simultaneous push and pop when full**: strobe aligned with a frame-start cycle while full.
  - No `overflow`.
  - `fifo_count` stays 4.
  - The new sample appears 4 frames later.
- **Negative sample and reset**:
  - Strobe 16'h8000: MSB 1 followed by fifteen 0s per channel.
  - Assert `reset` at bit 7 of the left channel: all outputs are 0 the same cycle, and `fifo_count`=0.
  - After release, the first frame starts 2·BCLK_DIV cycles later.
